// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// LSB first, WIDTH cycles per operation plus a one-cycle DONE result strobe.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    k_q, k_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             cmsb_q, cmsb_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bb_c;
  logic             sum_c;
  logic             cnext_c;
  logic             last_c;
  logic             msb_c;

  // Full-adder slice on the current LSBs, plus step-position decode.
  always_comb begin
    bb_c    = b_q[0] ^ mode_q;
    sum_c   = a_q[0] ^ bb_c ^ c_q;
    cnext_c = (a_q[0] & bb_c) | ((a_q[0] ^ bb_c) & c_q);
    last_c  = (k_q == CW'(WIDTH - 1));
    msb_c   = (WIDTH > 1) && (k_q == CW'(WIDTH - 2));
  end

  // Next-state and datapath update; outputs only change on the final step.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    k_d     = k_q;
    mode_d  = mode_q;
    c_d     = c_q;
    cmsb_d  = cmsb_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          r_d     = '0;
          mode_d  = mode;
          c_d     = ci ^ mode;
          // For WIDTH=1 the carry into the MSB is the initial carry itself.
          cmsb_d  = ci ^ mode;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        r_d = (r_q >> 1) | (WIDTH'(sum_c) << (WIDTH - 1));
        c_d = cnext_c;
        k_d = k_q + CW'(1);
        if (msb_c) begin
          cmsb_d = cnext_c;
        end
        if (last_c) begin
          s_d     = (r_q >> 1) | (WIDTH'(sum_c) << (WIDTH - 1));
          co_d    = cnext_c ^ mode_q;
          ovf_d   = cmsb_q ^ cnext_c;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      s_q    <= '0;
      k_q    <= '0;
      mode_q <= 1'b0;
      c_q    <= 1'b0;
      cmsb_q <= 1'b0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      s_q    <= s_d;
      k_q    <= k_d;
      mode_q <= mode_d;
      c_q    <= c_d;
      cmsb_q <= cmsb_d;
      co_q   <= co_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8 and WIDTH=1.
module tb_serial_add_sub;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;

  logic       start8, mode8, ci8;
  logic [7:0] a8, b8, s8;
  logic       co8, ovf8, busy8, done8;

  logic       start1, mode1, ci1;
  logic [0:0] a1, b1, s1;
  logic       co1, ovf1, busy1, done1;

  exp_t       q8[$];
  exp_t       q1[$];
  exp_t       e8, e1;
  int         busy_cnt8 = 0;
  int         busy_cnt1 = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8), .ci(ci8),
    .s(s8), .co(co8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  serial_add_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1), .ci(ci1),
    .s(s1), .co(co1), .ovf(ovf1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Word-level reference: add is a+b+ci, subtract is a-b-ci; co is the
  // unsigned carry/borrow, ovf the signed overflow of the add-domain sum.
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit ci, input bit mode);
    exp_t   e;
    longint mask, bb, full, sa, sb, ss;
    mask  = (longint'(1) << w) - 1;
    bb    = mode ? (~b & mask) : b;
    full  = a + bb + longint'(ci ^ mode);
    e.s   = 8'(full & mask);
    e.co  = mode ? (a < b + longint'(ci)) : (((full >> w) & 1) != 0);
    sa    = (a >> (w - 1)) & 1;
    sb    = (bb >> (w - 1)) & 1;
    ss    = (full >> (w - 1)) & 1;
    e.ovf = (sa == sb) && (ss != sa);
    e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] s, input logic co, input logic ovf);
    exp_t e;
    e.s = s; e.co = co; e.ovf = ovf; e.cyc = 0;
    return e;
  endfunction

  // WIDTH=8 result monitor.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      busy_cnt8 = 0;
    end else begin
      if (busy8 && done8) check("busy_done_overlap8", 1, 0);
      if (busy8) busy_cnt8++;
      if (done8) begin
        if (q8.size() == 0) begin
          check("spurious_done8", 1, 0);
        end else begin
          e8 = q8.pop_front();
          check("s8", 32'(s8), 32'(e8.s));
          check("co8", 32'(co8), 32'(e8.co));
          check("ovf8", 32'(ovf8), 32'(e8.ovf));
          check("done_latency8", cyc, e8.cyc);
          check("busy_len8", busy_cnt8, 8);
        end
        busy_cnt8 = 0;
      end
    end
  end

  // WIDTH=1 result monitor.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      busy_cnt1 = 0;
    end else begin
      if (busy1 && done1) check("busy_done_overlap1", 1, 0);
      if (busy1) busy_cnt1++;
      if (done1) begin
        if (q1.size() == 0) begin
          check("spurious_done1", 1, 0);
        end else begin
          e1 = q1.pop_front();
          check("s1", 32'(s1), 32'(e1.s));
          check("co1", 32'(co1), 32'(e1.co));
          check("ovf1", 32'(ovf1), 32'(e1.ovf));
          check("done_latency1", cyc, e1.cyc);
          check("busy_len1", busy_cnt1, 1);
        end
        busy_cnt1 = 0;
      end
    end
  end

  task automatic wait_q8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      check("timeout8", q8.size(), 0);
      q8.delete();
    end
  endtask

  task automatic wait_q1();
    int n = 0;
    while (q1.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0) begin
      check("timeout1", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit ci,
                     input bit mode, input exp_t e);
    exp_t x;
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; mode8 = mode; start8 = 1'b1;
    x = e;
    x.cyc = cyc + 1 + 8;
    q8.push_back(x);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    wait_q8();
  endtask

  task automatic op1(input bit a, input bit b, input bit ci, input bit mode);
    exp_t x;
    @(negedge clk);
    a1 = a; b1 = b; ci1 = ci; mode1 = mode; start1 = 1'b1;
    x = model(1, longint'(a), longint'(b), ci, mode);
    x.cyc = cyc + 1 + 1;
    q1.push_back(x);
    @(negedge clk);
    start1 = 1'b0;
    wait_q1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t        ops_e[3];
    logic [7:0]  ops_a[3], ops_b[3];
    bit          ops_ci[3], ops_m[3];
    logic [7:0]  ra, rb;
    bit          rc, rm;

    rst = 1'b1;
    start8 = 0; mode8 = 0; ci8 = 0; a8 = '0; b8 = '0;
    start1 = 0; mode1 = 0; ci1 = 0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("rst_s8", 32'(s8), 0);
    check("rst_co8", 32'(co8), 0);
    check("rst_ovf8", 32'(ovf8), 0);
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_done1", 32'(done1), 0);
    rst = 1'b0;

    // Directed WIDTH=8 vectors.
    op8(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0));
    op8(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
    op8(8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b1, 1'b0));
    op8(8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b0, 1'b1));
    op8(8'h10, 8'h0F, 1'b1, 1'b1, mk(8'h00, 1'b0, 1'b0));
    op8(8'h80, 8'h80, 1'b1, 1'b0, mk(8'h01, 1'b1, 1'b1));

    // Random WIDTH=8 against the word-level model.
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rm = 1'($urandom);
      op8(ra, rb, rc, rm, model(8, longint'(ra), longint'(rb), rc, rm));
    end

    // Start held high: new operands only in IDLE/DONE cycles, noise otherwise.
    ops_a[0] = 8'h3C; ops_b[0] = 8'h5A; ops_ci[0] = 1'b1; ops_m[0] = 1'b0;
    ops_a[1] = 8'h12; ops_b[1] = 8'h34; ops_ci[1] = 1'b0; ops_m[1] = 1'b1;
    ops_a[2] = 8'hC8; ops_b[2] = 8'hA0; ops_ci[2] = 1'b0; ops_m[2] = 1'b0;
    for (int i = 0; i < 3; i++)
      ops_e[i] = model(8, longint'(ops_a[i]), longint'(ops_b[i]), ops_ci[i], ops_m[i]);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      start8 = 1'b1;
      if (k % 9 == 0) begin
        a8 = ops_a[k / 9]; b8 = ops_b[k / 9];
        ci8 = ops_ci[k / 9]; mode8 = ops_m[k / 9];
        ops_e[k / 9].cyc = cyc + 1 + 8;
        q8.push_back(ops_e[k / 9]);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        ci8 = 1'($urandom); mode8 = 1'($urandom);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    wait_q8();

    // Reset during RUN aborts with no result and cleared outputs.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; ci8 = 0; mode8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", 32'(busy8), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_s8", 32'(s8), 0);
    check("abort_co8", 32'(co8), 0);
    check("abort_ovf8", 32'(ovf8), 0);
    check("abort_busy8", 32'(busy8), 0);
    check("abort_done8", 32'(done8), 0);
    repeat (12) @(negedge clk);
    op8(8'h21, 8'h43, 1'b1, 1'b0, mk(8'h65, 1'b0, 1'b0));

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 16; i++)
      op1(i[0], i[1], i[2], i[3]);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised bit-serial adder/subtractor: the multi-bit, sequential successor to the team's one-bit full-adder cell. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder slice with a registered carry. It returns sum/difference, carry/borrow-out and signed overflow with a one-cycle done pulse. It sits in the Experiment2 datapath wherever area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high; sampled on rising clk edge.
- start  in  1  request; sampled only when state is IDLE or DONE.
- mode  in  1  0 = add, 1 = subtract; latched with operands at accepted start.
- a  in  WIDTH  operand A; latched at accepted start.
- b  in  WIDTH  operand B; latched at accepted start.
- ci  in  1  carry-in (add) or borrow-in (subtract); latched at accepted start.
- s  out  WIDTH  result; valid while done=1 and held until the next accepted start.
- co  out  1  add: carry-out of MSB; subtract: borrow-out (1 when a < b + ci, unsigned).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB, computed in the internal add domain.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse when the result becomes valid.

## Operation
- States: IDLE, RUN, DONE. After reset the state is IDLE.
- IDLE with start=1: latch a into shift register A, b into B, and mode. Internal carry c = ci for add, c = ~ci for subtract. Clear bit counter k to 0. Go to RUN.
- RUN, each cycle:
  - Slice input bb = B[0] XOR mode.
  - Sum bit = A[0] ^ bb ^ c; it shifts into the MSB of result register R.
  - Carry updates: c = (A[0]&bb) | ((A[0]^bb)&c).
  - A and B shift right by one; k increments.
  - When k = WIDTH-2, also record cmsb = c, the carry into the MSB.
  - After the cycle with k = WIDTH-1, go to DONE.
- DONE, single cycle:
  - done=1. s=R.
  - co = c for add, co = ~c for subtract.
  - ovf = cmsb ^ c.
  - If start=1, accept it exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- start while RUN is ignored; no queuing.
- s, co and ovf hold their last values through IDLE and through the following RUN until the next DONE updates them. They are registered outputs.
- Arithmetic is modulo 2^WIDTH. Subtract computes a + ~b + ~ci, which equals a − b − ci.
- WIDTH=1: cmsb = ci in the add domain (c before the only step), so ovf = carry-in XOR carry-out. The block reduces to one full add of a, b, ci over one RUN cycle.
- Counter width is clog2(WIDTH) with a minimum of 1 bit.

## Timing
- Reset values, asserted on the first edge with rst=1:
  - state IDLE.
  - s=0, co=0, ovf=0, busy=0, done=0.
  - Internal registers are 0.
- rst has priority over every other input.
- rst in RUN aborts the operation: no done pulse, outputs cleared.
- Latency: start sampled at edge E0. busy=1 in cycles after E0 through edge E_WIDTH. done=1 for the one cycle after E_WIDTH.
- Throughput: back-to-back starts give one result every WIDTH+1 cycles. A start presented during DONE overlaps that DONE cycle.
- done and busy are never high together.
- Operand inputs may change freely after the accepted start edge.

## Test plan
- WIDTH=8, add:
  - a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1, ovf=0.
  - done high exactly 9 cycles after the start edge; busy high for 8 cycles.
- WIDTH=8, add: a=8'h7F, b=8'h01, ci=0 -> s=8'h80, co=0, ovf=1.
- WIDTH=8, subtract:
  - a=8'h05, b=8'h07, ci=0 -> s=8'hFE, co=1, ovf=0.
  - a=8'h80, b=8'h01, ci=0 -> s=8'h7F, co=0, ovf=1.
  - a=8'h10, b=8'h0F, ci=1 -> s=8'h00, co=0.
- Handshake:
  - start held high continuously -> results every 9 cycles; operand changes mid-RUN do not affect the result.
  - rst pulsed at RUN cycle 4 -> no done; all outputs 0; next start completes normally.
- WIDTH=1, exhaustive: all 16 (a,b,ci,mode) combinations -> s/co match the full-adder (mode=0) and full-subtractor (mode=1) truth tables; done is 2 cycles after start.
